// File: rtl/bus_arbiter_if.sv
// BrainForge8 bus-mastership handshake bundle shared by the arbiter and its requesters.
// BR is the requester's "valid": it is raised to ask for the bus and held level for the whole tenure.
// BA is the grant: a requester may drive the bus only while its BA bit is high.
// Dropping BR ends the tenure, and BA falling without a BR drop means the bus was revoked.
interface bus_arbiter_if #(
    parameter int N  = 4,
    parameter int OW = $clog2(N)
);
    logic          HLD;
    logic [N-1:0]  BR;
    logic [N-1:0]  BA;
    logic [OW-1:0] OWNER;
    logic          BUSY;
    logic          TIMEOUT;

    modport master (output HLD, BR, input BA, OWNER, BUSY, TIMEOUT);
    modport slave  (input HLD, BR, output BA, OWNER, BUSY, TIMEOUT);
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin BR/BA bus arbiter with turnaround dead cycles and a hold-time revoke.
// The winning requester owns the bus until it drops BR, or until it is revoked after MAX_HOLD cycles while others wait.
module bus_arbiter #(
    parameter int N        = 4,
    parameter int OW       = $clog2(N),
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic         CLK,
    input  logic         RST,
    bus_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam bit           HOLD_EN    = (MAX_HOLD != 0);
    localparam logic [7:0]   HOLD_LIMIT = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [3:0]   TURN_LAST  = 4'(TURN_CYC - 1);

    state_t        state;
    logic [N-1:0]  ba_q;
    logic [OW-1:0] owner_q;
    logic          timeout_q;
    logic [OW-1:0] ptr;
    logic [7:0]    tenure;
    logic [3:0]    turn_cnt;

    logic          win_valid;
    logic [OW-1:0] win_idx;
    logic [OW-1:0] scan_idx;
    logic [N-1:0]  win_onehot;
    logic          owner_req;
    logic          other_req;

    // Scan from the highest offset down so the lowest offset from ptr ends up as the winner.
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = '0;
        scan_idx   = '0;
        win_onehot = '0;
        for (int j = N - 1; j >= 0; j--) begin
            scan_idx = ptr + OW'(j);
            if (bus.BR[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    // During GRANT, ba_q is exactly the owner's one-hot bit.
    assign owner_req = |(bus.BR & ba_q);
    assign other_req = |(bus.BR & ~ba_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ba_q      <= '0;
            owner_q   <= '0;
            timeout_q <= 1'b0;
            ptr       <= '0;
            tenure    <= '0;
            turn_cnt  <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.HLD && win_valid) begin
                        ba_q    <= win_onehot;
                        owner_q <= win_idx;
                        ptr     <= win_idx + OW'(1);
                        tenure  <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (tenure != 8'hff) begin
                        tenure <= tenure + 8'd1;
                    end
                    // A release takes precedence over a revoke, so no TIMEOUT then.
                    if (!owner_req) begin
                        ba_q     <= '0;
                        turn_cnt <= '0;
                        state    <= TURN;
                    end else if (HOLD_EN && (tenure >= HOLD_LIMIT) && other_req) begin
                        ba_q      <= '0;
                        turn_cnt  <= '0;
                        timeout_q <= 1'b1;
                        state     <= TURN;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ba_q  <= '0;
                end
            endcase
        end
    end

    assign bus.BA      = ba_q;
    assign bus.OWNER   = owner_q;
    assign bus.BUSY    = |ba_q;
    assign bus.TIMEOUT = timeout_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: cycle vectors, directed multi-cycle sequences, and random traffic
// checked every cycle against a tenure/deadline model of the arbitration rules.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] dbg0;
    logic [1:0] dbg1;
    int         tests;
    int         failed;
    int         cyc;
    bit         chk_en;

    bus_arbiter_if #(.N(4)) bus0 ();
    bus_arbiter_if #(.N(4)) bus1 ();

    bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYC(1)) dut0 (
        .CLK(clk), .RST(rst), .bus(bus0), .dbg_state(dbg0)
    );
    bus_arbiter #(.N(4), .MAX_HOLD(0), .TURN_CYC(3)) dut1 (
        .CLK(clk), .RST(rst), .bus(bus1), .dbg_state(dbg1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Model: who holds the bus, since which edge, and the first edge a new decision may happen.
    typedef struct {
        int cur;
        int owner;
        int ptr;
        int grant_edge;
        int free_at;
        bit timeout;
    } model_t;

    model_t m0 = '{cur: -1, owner: 0, ptr: 0, grant_edge: 0, free_at: 0, timeout: 1'b0};
    model_t m1 = '{cur: -1, owner: 0, ptr: 0, grant_edge: 0, free_at: 0, timeout: 1'b0};

    function automatic model_t model_step(input model_t s, input bit r, input bit hld,
                                          input logic [3:0] br, input int k,
                                          input int max_hold, input int turn_cyc);
        model_t n;
        logic [3:0] mine;
        bit found;
        int c;
        n = s;
        n.timeout = 1'b0;
        if (r) begin
            n.cur = -1; n.owner = 0; n.ptr = 0; n.free_at = k + 1;
        end else if (s.cur >= 0) begin
            mine = 4'b0001 << s.cur;
            if ((br & mine) == 4'b0000) begin
                n.cur = -1; n.free_at = k + turn_cyc + 1;
            end else if (max_hold != 0 && (k - s.grant_edge) >= max_hold && (br & ~mine) != 4'b0000) begin
                n.cur = -1; n.timeout = 1'b1; n.free_at = k + turn_cyc + 1;
            end
        end else if (k >= s.free_at && !hld && br != 4'b0000) begin
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
                c = (s.ptr + j) % 4;
                if (!found && br[c]) begin
                    found = 1'b1;
                    n.cur = c; n.owner = c; n.ptr = (c + 1) % 4; n.grant_edge = k;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] model_ba(input model_t m);
        logic [3:0] one;
        one = 4'b0001;
        return (m.cur >= 0) ? (one << m.cur) : 4'b0000;
    endfunction

    always @(posedge clk) begin
        m0 <= model_step(m0, rst, bus0.HLD, bus0.BR, cyc, 8, 1);
        m1 <= model_step(m1, rst, bus1.HLD, bus1.BR, cyc, 0, 3);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m0_ba", bus0.BA, model_ba(m0));
            check("m0_owner", bus0.OWNER, m0.owner);
            check("m0_busy", bus0.BUSY, |model_ba(m0));
            check("m0_timeout", bus0.TIMEOUT, m0.timeout);
            check("m1_ba", bus1.BA, model_ba(m1));
            check("m1_owner", bus1.OWNER, m1.owner);
            check("m1_busy", bus1.BUSY, |model_ba(m1));
            check("m1_timeout", bus1.TIMEOUT, m1.timeout);
        end
    end

    typedef struct {
        logic       rst;
        logic       hld;
        logic [3:0] br;
        logic [3:0] ba;
        logic [1:0] owner;
        logic       tmo;
    } vec_t;

    vec_t vecs [0:28];

    task automatic set_vec(input int i, input logic r, input logic h, input logic [3:0] br,
                           input logic [3:0] ba, input logic [1:0] ow, input logic t);
        vecs[i] = '{rst: r, hld: h, br: br, ba: ba, owner: ow, tmo: t};
    endtask

    initial begin : main
        logic [3:0] br_v;
        int held, gap, idx, t, found;
        int order[$];

        tests = 0; failed = 0; cyc = 0; chk_en = 1'b0;
        rst = 1'b1;
        bus0.HLD = 1'b0; bus0.BR = 4'b0000;
        bus1.HLD = 1'b0; bus1.BR = 4'b0000;

        // single request, release, dead cycles, re-grant
        set_vec(0,  1, 0, 4'b0000, 4'b0000, 2'd0, 0);
        set_vec(1,  0, 0, 4'b0010, 4'b0010, 2'd1, 0);
        set_vec(2,  0, 0, 4'b0010, 4'b0010, 2'd1, 0);
        set_vec(3,  0, 0, 4'b0010, 4'b0010, 2'd1, 0);
        set_vec(4,  0, 0, 4'b0010, 4'b0010, 2'd1, 0);
        set_vec(5,  0, 0, 4'b0010, 4'b0010, 2'd1, 0);
        set_vec(6,  0, 0, 4'b0000, 4'b0000, 2'd1, 0);
        set_vec(7,  0, 0, 4'b0010, 4'b0000, 2'd1, 0);
        set_vec(8,  0, 0, 4'b0010, 4'b0010, 2'd1, 0);
        set_vec(9,  0, 0, 4'b0000, 4'b0000, 2'd1, 0);
        set_vec(10, 0, 0, 4'b0000, 4'b0000, 2'd1, 0);
        // HLD blocks new grants only
        set_vec(11, 0, 1, 4'b0100, 4'b0000, 2'd1, 0);
        set_vec(12, 0, 1, 4'b0100, 4'b0000, 2'd1, 0);
        set_vec(13, 0, 1, 4'b0100, 4'b0000, 2'd1, 0);
        set_vec(14, 0, 0, 4'b0100, 4'b0100, 2'd2, 0);
        set_vec(15, 0, 1, 4'b0100, 4'b0100, 2'd2, 0);
        set_vec(16, 0, 1, 4'b0100, 4'b0100, 2'd2, 0);
        set_vec(17, 0, 0, 4'b1000, 4'b0000, 2'd2, 0);
        set_vec(18, 0, 0, 4'b1000, 4'b0000, 2'd2, 0);
        set_vec(19, 0, 0, 4'b1000, 4'b1000, 2'd3, 0);
        set_vec(20, 0, 0, 4'b1000, 4'b1000, 2'd3, 0);
        // reset mid-tenure, then pointer back at 0
        set_vec(21, 1, 0, 4'b1000, 4'b0000, 2'd0, 0);
        set_vec(22, 0, 0, 4'b1001, 4'b0001, 2'd0, 0);
        set_vec(23, 0, 0, 4'b1001, 4'b0001, 2'd0, 0);
        set_vec(24, 0, 0, 4'b1000, 4'b0000, 2'd0, 0);
        set_vec(25, 0, 0, 4'b1000, 4'b0000, 2'd0, 0);
        set_vec(26, 0, 0, 4'b1000, 4'b1000, 2'd3, 0);
        set_vec(27, 0, 0, 4'b0000, 4'b0000, 2'd3, 0);
        set_vec(28, 0, 0, 4'b0000, 4'b0000, 2'd3, 0);

        for (int i = 0; i < 29; i++) begin
            rst = vecs[i].rst;
            bus0.HLD = vecs[i].hld;
            bus0.BR = vecs[i].br;
            @(negedge clk);
            check($sformatf("vec%0d_ba", i), bus0.BA, vecs[i].ba);
            check($sformatf("vec%0d_owner", i), bus0.OWNER, vecs[i].owner);
            check($sformatf("vec%0d_busy", i), bus0.BUSY, |vecs[i].ba);
            check($sformatf("vec%0d_timeout", i), bus0.TIMEOUT, vecs[i].tmo);
            chk_en = 1'b1;
        end
        rst = 1'b0;
        bus0.HLD = 1'b0;

        // round-robin with every master releasing after 3 cycles
        br_v = 4'hf; held = 0; gap = 0;
        bus0.BR = br_v;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            @(negedge clk);
            br_v = 4'hf;
            check("rr_onehot", ($countones(bus0.BA) <= 1), 1);
            if (bus0.BA != 4'b0000) begin
                idx = onehot_idx(bus0.BA);
                if (held == 0) begin
                    order.push_back(idx);
                    if (order.size() > 1) check("rr_gap", gap, 2);
                end
                held++;
                gap = 0;
                if (held == 3) begin
                    br_v[idx] = 1'b0;
                    held = 0;
                end
            end else begin
                gap++;
            end
            bus0.BR = br_v;
        end
        check("rr_count", order.size(), 5);
        for (int k = 0; k < order.size(); k++) check($sformatf("rr_order%0d", k), order[k], k % 4);
        bus0.BR = 4'b0000;
        repeat (3) @(negedge clk);

        // revoke after MAX_HOLD cycles, revoked master goes last
        bus0.BR = 4'b0100;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk);
            if (bus0.BA == 4'b0100) found = 1;
        end
        check("to_grant2", found, 1);
        t = 1;
        for (int c = 0; c < 20 && bus0.BA == 4'b0100; c++) begin
            if (t == 3) bus0.BR = 4'b0101;
            @(negedge clk);
            if (bus0.BA == 4'b0100) t++;
        end
        check("to_hold_len", t, 8);
        check("to_pulse", bus0.TIMEOUT, 1);
        @(negedge clk);
        check("to_pulse_end", bus0.TIMEOUT, 0);
        check("to_gap_ba", bus0.BA, 4'b0000);
        @(negedge clk);
        check("to_grant0", bus0.BA, 4'b0001);
        @(negedge clk);
        check("to_hold0", bus0.BA, 4'b0001);
        bus0.BR = 4'b0100;
        repeat (2) @(negedge clk);
        check("to_dead", bus0.BA, 4'b0000);
        @(negedge clk);
        check("to_regrant2", bus0.BA, 4'b0100);
        bus0.BR = 4'b0000;
        repeat (3) @(negedge clk);

        // unlimited hold on the MAX_HOLD=0 instance
        bus1.BR = 4'b1000;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk);
            if (bus1.BA == 4'b1000) found = 1;
        end
        check("uh_grant3", found, 1);
        bus1.BR = 4'b1010;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            check("uh_hold", bus1.BA, 4'b1000);
            check("uh_no_timeout", bus1.TIMEOUT, 0);
        end
        bus1.BR = 4'b0010;
        gap = 0;
        for (int c = 0; c < 10 && bus1.BA != 4'b0010; c++) begin
            @(negedge clk);
            if (bus1.BA == 4'b0000) gap++;
        end
        check("uh_gap", gap, 4);
        check("uh_grant1", bus1.BA, 4'b0010);
        bus1.BR = 4'b0000;
        repeat (5) @(negedge clk);

        // random traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 7) == 0) bus0.HLD = ~bus0.HLD;
            if ($urandom_range(0, 7) == 0) bus1.HLD = ~bus1.HLD;
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 5) == 0) bus0.BR[j] = ~bus0.BR[j];
                if ($urandom_range(0, 5) == 0) bus1.BR[j] = ~bus1.BR[j];
            end
        end
        rst = 1'b0;
        bus0.BR = 4'b0000; bus0.HLD = 1'b0;
        bus1.BR = 4'b0000; bus1.HLD = 1'b0;
        repeat (6) @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
